// File: rtl/aes_spi_pkg.sv
// rtl/aes_spi_pkg.sv - shared types and sizing for the AES SPI master
// Contents: FSM state enum, data block width, bit counter width, key size helper.
package aes_spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND_DATA,
      SEND_KEY,
      WAIT,
      RECV,
      DONE
   } spi_state_t;

   localparam int DATA_BITS = 128;
   localparam int CNT_BITS  = 9;

   function automatic int key_bits(input int nk);
      return 32 * nk;
   endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - MSB-first shift register with parallel load
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears register)
//   load, load_data     parallel load, takes priority over shifting
//   shift_en, serial_in shift left by one, serial_in enters at bit 0
//   serial_out          current MSB
//   q                   full register contents
module spi_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   input  logic             serial_in,
   output logic             serial_out,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_data;
      end else if (shift_en) begin
         q <= {q[WIDTH-2:0], serial_in};
      end
   end

   assign serial_out = q[WIDTH-1];

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master sending an AES block and key, reading back the result
// Build option: SPI_MASTER_READBACK_EN enables the WAIT/RECV readback phases;
// without it the frame ends after the key and data_out stays 0.
// Ports:
//   clk, rst           system/shift clock, synchronous active-high reset
//   start              begin a frame (only honoured in IDLE)
//   data_in, key_in    plaintext block and key, captured when the frame starts
//   CS, MOSI, MISO     SPI lines (CS active low)
//   busy, done         busy outside IDLE, done is a one-cycle end-of-frame pulse
//   data_out           received block, held until the next done
module spi_master
   import aes_spi_pkg::*;
#(
   parameter int Nk          = 4,
   parameter int Nr          = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [DATA_BITS-1:0]     data_in,
   input  logic [key_bits(Nk)-1:0]  key_in,
   output logic                     CS,
   output logic                     MOSI,
   input  logic                     MISO,
   output logic                     busy,
   output logic                     done,
   output logic [DATA_BITS-1:0]     data_out
);

   localparam int KEY_BITS = key_bits(Nk);
   localparam int TX_BITS  = DATA_BITS + KEY_BITS;

   localparam logic [CNT_BITS-1:0] DATA_LAST = CNT_BITS'(DATA_BITS - 1);
   localparam logic [CNT_BITS-1:0] KEY_LAST  = CNT_BITS'(KEY_BITS - 1);
`ifdef SPI_MASTER_READBACK_EN
   localparam logic [CNT_BITS-1:0] WAIT_LAST = CNT_BITS'(WAIT_CYCLES - 1);
`endif

   spi_state_t          state;
   spi_state_t          state_next;
   logic [CNT_BITS-1:0] cnt;

   logic                tx_load;
   logic                tx_shift;
   logic                tx_sout;
   logic [TX_BITS-1:0]  tx_q;

   logic                rx_shift;
   logic                rx_sout;
   logic [DATA_BITS-1:0] rx_q;

   logic                unused_tie;

   // State register and per-state bit counter; the counter restarts on every
   // transition so each phase compares against its own last index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (state_next != state) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) state_next = SEND_DATA;
         end
         SEND_DATA: begin
            if (cnt == DATA_LAST) state_next = SEND_KEY;
         end
         SEND_KEY: begin
            if (cnt == KEY_LAST) begin
`ifdef SPI_MASTER_READBACK_EN
               state_next = (WAIT_CYCLES == 0) ? RECV : WAIT;
`else
               state_next = DONE;
`endif
            end
         end
`ifdef SPI_MASTER_READBACK_EN
         WAIT: begin
            if (cnt == WAIT_LAST) state_next = RECV;
         end
         RECV: begin
            if (cnt == DATA_LAST) state_next = DONE;
         end
`endif
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      CS       = 1'b1;
      MOSI     = 1'b0;
      busy     = (state != IDLE);
      done     = 1'b0;
      tx_shift = 1'b0;
      rx_shift = 1'b0;
      case (state)
         SEND_DATA, SEND_KEY: begin
            CS       = 1'b0;
            MOSI     = tx_sout;
            tx_shift = 1'b1;
         end
         WAIT: begin
            CS = 1'b0;
         end
         RECV: begin
            CS       = 1'b0;
            rx_shift = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Data and key are sent back-to-back, so one register holds both.
   assign tx_load = (state == IDLE) && start;

   spi_shift_reg #(
      .WIDTH(TX_BITS)
   ) u_tx (
      .clk       (clk),
      .rst       (rst),
      .load      (tx_load),
      .load_data ({data_in, key_in}),
      .shift_en  (tx_shift),
      .serial_in (1'b0),
      .serial_out(tx_sout),
      .q         (tx_q)
   );

   spi_shift_reg #(
      .WIDTH(DATA_BITS)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .load      (1'b0),
      .load_data ('0),
      .shift_en  (rx_shift),
      .serial_in (MISO),
      .serial_out(rx_sout),
      .q         (rx_q)
   );

   // data_out is written on entry to DONE so it is already valid while done
   // is high; the last MISO bit is merged here because the RX register only
   // absorbs it on that same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
`ifdef SPI_MASTER_READBACK_EN
      end else if ((state == RECV) && (state_next == DONE)) begin
         data_out <= {rx_q[DATA_BITS-2:0], MISO};
`endif
      end
   end

`ifdef SPI_MASTER_READBACK_EN
   assign unused_tie = ^{tx_q, rx_sout, rx_q[DATA_BITS-1], 1'(Nr)};
`else
   assign unused_tie = ^{tx_q, rx_sout, rx_q, MISO, 1'(Nr), 1'(WAIT_CYCLES)};
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master (Nk=4 and Nk=8)
module tb_spi_master;

`ifdef SPI_MASTER_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif

   localparam int WAITC = 2;

   localparam logic [127:0] DATA = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY4 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] KEY8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] W2   = 128'hdeadbeef0123456789abcdeffedcba98;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start4 = 1'b0;
   logic         start8 = 1'b0;
   logic [127:0] data_in = '0;
   logic [127:0] key4 = '0;
   logic [255:0] key8 = '0;
   logic         MISO = 1'b0;

   logic         cs4, mosi4, busy4, done4;
   logic         cs8, mosi8, busy8, done8;
   logic [127:0] dout4, dout8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_master #(.Nk(4), .Nr(10), .WAIT_CYCLES(WAITC)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .data_in(data_in), .key_in(key4),
      .CS(cs4), .MOSI(mosi4), .MISO(MISO), .busy(busy4), .done(done4), .data_out(dout4)
   );

   spi_master #(.Nk(8), .Nr(14), .WAIT_CYCLES(WAITC)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .data_in(data_in), .key_in(key8),
      .CS(cs8), .MOSI(mosi8), .MISO(MISO), .busy(busy8), .done(done8), .data_out(dout8)
   );

   task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one frame on the selected DUT from a negedge. Captures the MOSI
   // stream, counts CS-high cycles inside the frame, counts MOSI=1 after the
   // TX phase, drives MISO during the expected RECV window, and returns the
   // cycle (1 = first cycle after the start edge) in which done is seen.
   task automatic run_frame(input int nk, input logic [127:0] miso_word, input bit hold,
                            output int done_cyc, output logic [383:0] mosi_bits,
                            output int cs_gaps, output int mosi_extra);
      int  tx_last;
      int  rx_first;
      logic cs_v, mosi_v, done_v;
      tx_last    = 128 + 32 * nk;
      rx_first   = 1 + tx_last + WAITC;
      done_cyc   = -1;
      mosi_bits  = '0;
      cs_gaps    = 0;
      mosi_extra = 0;
      if (nk == 8) start8 = 1'b1; else start4 = 1'b1;
      for (int c = 1; c <= 700 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (!hold) begin
            start4 = 1'b0;
            start8 = 1'b0;
            if (c == 50) begin
               // start while busy and changed inputs must not disturb the frame
               if (nk == 8) start8 = 1'b1; else start4 = 1'b1;
               data_in = ~DATA;
               key4    = ~KEY4;
               key8    = ~KEY8;
            end
         end
         cs_v   = (nk == 8) ? cs8 : cs4;
         mosi_v = (nk == 8) ? mosi8 : mosi4;
         done_v = (nk == 8) ? done8 : done4;
         if (c <= tx_last) mosi_bits[383 - (c - 1)] = mosi_v;
         else if (!done_v && mosi_v !== 1'b0) mosi_extra++;
         if (done_v === 1'b1) done_cyc = c;
         else if (cs_v !== 1'b0) cs_gaps++;
         if (c >= rx_first && c < rx_first + 128) MISO = miso_word[127 - (c - rx_first)];
         else MISO = 1'b0;
      end
   endtask

   int           dc, gaps, extra, dcount, cshigh;
   logic [383:0] mb;

   initial begin
      // reset state
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_cs", cs4, 1'b1);
      chk("rst_mosi", mosi4, 1'b0);
      chk("rst_busy", busy4, 1'b0);
      chk("rst_done", done4, 1'b0);
      chk("rst_dout", dout4, 128'h0);
      @(negedge clk);
      chk("idle_cs_stays", cs4, 1'b1);

      // Nk=4 frame with readback vector, start pulse and input change mid-frame
      data_in = DATA;
      key4    = KEY4;
      run_frame(4, CT, 1'b0, dc, mb, gaps, extra);
      chk("f1_done_cycle", dc, READBACK ? (1 + 128 + 128 + WAITC + 128) : (1 + 128 + 128));
      chk("f1_mosi_stream", mb, {DATA, KEY4, 128'h0});
      chk("f1_cs_gaps", gaps, 0);
      chk("f1_mosi_idle_zero", extra, 0);
      chk("f1_busy_at_done", busy4, 1'b1);
      chk("f1_cs_at_done", cs4, 1'b1);
      chk("f1_dout", dout4, READBACK ? CT : 128'h0);
      @(negedge clk);
      chk("f1_done_one_cycle", done4, 1'b0);
      chk("f1_idle_busy", busy4, 1'b0);
      @(negedge clk);
      chk("f1_no_queued_start", busy4, 1'b0);
      chk("f1_dout_held", dout4, READBACK ? CT : 128'h0);

      // start held high: one frame, then a new frame right after IDLE
      data_in = DATA;
      key4    = KEY4;
      run_frame(4, W2, 1'b1, dc, mb, gaps, extra);
      chk("f2_done_cycle", dc, READBACK ? 387 : 257);
      chk("f2_dout", dout4, READBACK ? W2 : 128'h0);
      @(negedge clk);
      chk("f2_idle_between", busy4, 1'b0);
      @(negedge clk);
      chk("f2_restart_busy", busy4, 1'b1);
      chk("f2_restart_cs", cs4, 1'b0);
      start4 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // reset at SEND_DATA cycle 100 aborts without done
      data_in = 128'h80000000000000000000000000000001;
      key4    = KEY4;
      start4  = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (c == 99) chk("abort_mosi_mid", mosi4, 1'b0);
         if (c == 100) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      chk("abort_cs", cs4, 1'b1);
      chk("abort_busy", busy4, 1'b0);
      chk("abort_done", done4, 1'b0);
      chk("abort_dout", dout4, 128'h0);
      dcount = 0;
      cshigh = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (done4 === 1'b1) dcount++;
         if (cs4 === 1'b1) cshigh++;
      end
      chk("abort_no_done", dcount, 0);
      chk("abort_cs_high", cshigh, 400);

      // Nk=8 frame
      data_in = DATA;
      key8    = KEY8;
      run_frame(8, CT, 1'b0, dc, mb, gaps, extra);
      chk("k8_done_cycle", dc, READBACK ? (1 + 128 + 256 + WAITC + 128) : (1 + 128 + 256));
      chk("k8_mosi_stream", mb, {DATA, KEY8});
      chk("k8_cs_gaps", gaps, 0);
      chk("k8_mosi_idle_zero", extra, 0);
      chk("k8_dout", dout8, READBACK ? CT : 128'h0);
      @(negedge clk);
      chk("k8_idle_busy", busy8, 1'b0);

      // reset wins over start in the same cycle
      rst    = 1'b1;
      start4 = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      start4 = 1'b0;
      chk("rst_prio_busy", busy4, 1'b0);
      chk("rst_prio_cs", cs4, 1'b1);
      @(negedge clk);
      chk("rst_prio_still_idle", busy4, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have parameter Nk, default 4, key length in 32-bit words (4/6/8).
REQ-002 The block SHALL have parameter Nr, default 10, round count; passed through only, no function here.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, idle shift cycles between key send and readback.
REQ-004 The block SHALL have port clk  input  1  single system clock; all logic on posedge; also the SPI shift clock.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port start  input  1  request a transfer; sampled only in IDLE.
REQ-007 The block SHALL have port data_in  input  128  plaintext block.
REQ-008 The block SHALL have port key_in  input  32*Nk  cipher key.
REQ-009 The block SHALL have port CS  output  1  active-low chip select to slave.
REQ-010 The block SHALL have port MOSI  output  1  serial data to slave SDI.
REQ-011 The block SHALL have port MISO  input  1  serial data from slave SDO.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse at end of transfer.
REQ-014 The block SHALL have port data_out  output  128  received ciphertext, held until next done.

Function
REQ-015 The FSM SHALL have states IDLE, SEND_DATA, SEND_KEY, WAIT, RECV, DONE; one bit counter, 9 bits wide, clear on every state change.
REQ-016 In IDLE with start=1 at a posedge, the block SHALL capture data_in/key_in into TX shift regs, go to SEND_DATA, drive CS=0 and MOSI=data_in[127] in the next cycle.
REQ-017 SEND_DATA SHALL shift MSB-first, one bit per clk, for exactly 128 cycles, then enter SEND_KEY with MOSI=key MSB.
REQ-018 SEND_KEY SHALL shift 32*Nk bits MSB-first, one per clk, then enter WAIT.
REQ-019 WAIT SHALL hold CS=0, MOSI=0 for WAIT_CYCLES cycles (0 = skip state), then enter RECV.
REQ-020 RECV SHALL sample MISO on each of 128 posedges, shifting into an RX reg MSB-first (first bit ends as data_out[127]).
REQ-021 DONE SHALL last one cycle: CS=1, done=1, data_out<=RX reg; next state IDLE.
REQ-022 start-to-done latency SHALL be 1+128+32*Nk+WAIT_CYCLES+128 cycles; Nk=4, WAIT_CYCLES=2: 387.
REQ-023 CS SHALL stay low continuously from first SEND_DATA cycle to last RECV cycle; no gaps.
REQ-024 start asserted while busy=1 SHALL be ignored, not queued; data_in/key_in changes mid-transfer SHALL not affect the frame.
REQ-025 In IDLE, CS SHALL be 1, MOSI 0, done 0.

Reset
REQ-026 With rst=1 at a posedge, the block SHALL go to IDLE next cycle: CS=1, MOSI=0, busy=0, done=0, data_out=0, counter and TX/RX regs 0.
REQ-027 Reset mid-transfer SHALL abort without a done pulse; slave sees CS rise and discards its state.
REQ-028 rst SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro SPI_MASTER_READBACK_EN defined: WAIT and RECV SHALL be present as above.
REQ-030 Macro undefined: SEND_KEY SHALL go directly to DONE, data_out SHALL remain 0, MISO unused; latency 1+128+32*Nk.

Structure
REQ-031 Package aes_spi_pkg SHALL hold the FSM state enum typedef, DATA_BITS=128, and function key_bits(Nk)=32*Nk.
REQ-032 One sub-module, spi_shift_reg (parameterised width, load, shift-enable, serial in/out, MSB-first), SHALL be instantiated twice: TX (data+key concatenated) and RX.

Verification
REQ-033 Scenario: Nk=4, data_in=00112233445566778899aabbccddeeff, key_in=000102030405060708090a0b0c0d0e0f, start pulse -> MOSI stream equals data then key MSB-first, 256 bits, CS low throughout.
REQ-034 Scenario: MISO driven with 69c4e0d86a7b0430d8cdb78070b4c55a MSB-first during RECV -> done at cycle 387, data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-035 Scenario: Nk=8, key_in=000102...1e1f -> SEND_KEY lasts 256 cycles, done at cycle 515.
REQ-036 Scenario: rst asserted at cycle 100 of SEND_DATA -> next cycle CS=1, busy=0, no done, data_out unchanged at 0.
REQ-037 Scenario: start held high for whole transfer -> exactly one frame, then a second frame starts the cycle after done (IDLE samples start).
REQ-038 Scenario: SPI_MASTER_READBACK_EN undefined, Nk=4 -> done at cycle 257, data_out=0.
